// File: rtl/mem_access_stage_if.sv
// Word-wide data-memory port with req/ack handshake between the MEM stage and data memory.
interface mem_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues single-beat load/store requests, aligns/extends load data, stalls until done.
// Optional misalignment trap (IDLE -> DONE with mem_err/mem_ale, no request) enabled by MEM_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a valid load/store from EX/MEM
// REQ   | dm_req held, waiting for dm_ack or timeout
// DONE  | one-cycle completion, mem_done high, pipeline advances
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid_in,
  input  logic [4:0]                mem_op,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  mem_access_stage_if.master        dm,
  output logic [31:0]               mem_rdata_out,
  output logic                      mem_done,
  output logic                      mem_err,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                      mem_ale,
`endif
  output logic                      mem_stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] wait_cnt;
  logic        store_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lo_q;

  logic        op_load, op_store, op_uns;
  logic [1:0]  op_size;
  logic        access;
  logic        misalign;
  logic [3:0]  strb_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  assign op_load  = mem_op[4];
  assign op_store = mem_op[3];
  assign op_uns   = mem_op[2];
  assign op_size  = mem_op[1:0];
  assign access   = mem_valid_in & (op_load ^ op_store) & (op_size != 2'b11);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((op_size == 2'b01) & mem_addr[0]) |
                    ((op_size == 2'b10) & (mem_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign mem_stall = ((state == IDLE) & access) | (state == REQ);

  always_comb begin
    strb_nxt  = 4'b1111;
    wdata_nxt = mem_wdata;
    case (op_size)
      2'b00: begin
        strb_nxt  = 4'b0001 << mem_addr[1:0];
        wdata_nxt = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        strb_nxt  = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!op_store) strb_nxt = 4'b0000;
  end

  assign byte_v = 8'(dm.dm_rdata >> {lo_q, 3'b000});
  assign half_v = 16'(dm.dm_rdata >> {lo_q[1], 4'b0000});

  always_comb begin
    load_data = dm.dm_rdata;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_data = uns_q ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      store_q       <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'b00;
      lo_q          <= 2'b00;
      dm.dm_req     <= 1'b0;
      dm.dm_we      <= 1'b0;
      dm.dm_wstrb   <= 4'b0000;
      dm.dm_addr    <= '0;
      dm.dm_wdata   <= '0;
      mem_rdata_out <= '0;
      mem_done      <= 1'b0;
      mem_err       <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mem_ale       <= 1'b0;
`endif
    end else begin
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mem_ale  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (access) begin
            if (misalign) begin
              mem_rdata_out <= '0;
              mem_done      <= 1'b1;
              mem_err       <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
              mem_ale       <= 1'b1;
`endif
              state         <= DONE;
            end else begin
              store_q     <= op_store;
              uns_q       <= op_uns;
              size_q      <= op_size;
              lo_q        <= mem_addr[1:0];
              dm.dm_req   <= 1'b1;
              dm.dm_we    <= op_store;
              dm.dm_wstrb <= strb_nxt;
              dm.dm_addr  <= {mem_addr[31:2], 2'b00};
              dm.dm_wdata <= wdata_nxt;
              wait_cnt    <= '0;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          // ack takes priority over a timeout landing in the same cycle
          if (dm.dm_ack) begin
            dm.dm_req     <= 1'b0;
            mem_rdata_out <= store_q ? 32'h0 : load_data;
            mem_done      <= 1'b1;
            state         <= DONE;
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
            dm.dm_req     <= 1'b0;
            mem_rdata_out <= '0;
            mem_done      <= 1'b1;
            mem_err       <= 1'b1;
            state         <= DONE;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, delayed ack, timeout, reset mid-request, misalignment.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid_in = 1'b0;
  logic [4:0]  mem_op = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata_out;
  logic        mem_done, mem_err, mem_stall;

  logic        valid_b = 1'b0;
  logic [4:0]  op_b = '0;
  logic [31:0] addr_b = '0;
  logic [31:0] rdata_b;
  logic        done_b, err_b, stall_b;

`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_ale, ale_b;
`endif

  mem_access_stage_if dm_a ();
  mem_access_stage_if dm_b ();

  always #5 clk = ~clk;

  mem_access_stage u_dut (
    .clk(clk), .rst(rst), .mem_valid_in(mem_valid_in), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dm(dm_a.master),
    .mem_rdata_out(mem_rdata_out), .mem_done(mem_done), .mem_err(mem_err),
`ifdef MEM_ALIGN_CHECK_EN
    .mem_ale(mem_ale),
`endif
    .mem_stall(mem_stall)
  );

  mem_access_stage #(.TIMEOUT(3)) u_dut_to (
    .clk(clk), .rst(rst), .mem_valid_in(valid_b), .mem_op(op_b),
    .mem_addr(addr_b), .mem_wdata(32'h0), .dm(dm_b.master),
    .mem_rdata_out(rdata_b), .mem_done(done_b), .mem_err(err_b),
`ifdef MEM_ALIGN_CHECK_EN
    .mem_ale(ale_b),
`endif
    .mem_stall(stall_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  int          obs_stall, obs_req, obs_done, obs_lat;
  logic        obs_stable, obs_err, obs_we;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_strb;

  // Starts just after a rising edge; ack_dly = REQ cycles without ack before the acking one.
  task automatic run_access(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_dly, input logic [31:0] rdata);
    mem_valid_in = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wdata;
    obs_stall = 0; obs_req = 0; obs_done = 0; obs_lat = 0; obs_stable = 1'b1;
    obs_err = 1'b0; obs_rdata = '0; obs_addr = '0; obs_wdata = '0; obs_strb = '0; obs_we = 1'b0;
    @(negedge clk);
    if (mem_stall) obs_stall++;
    @(posedge clk); #1;
    mem_valid_in = 1'b0; mem_op = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (dm_a.dm_req && obs_req == ack_dly) begin
        dm_a.dm_ack = 1'b1; dm_a.dm_rdata = rdata;
      end
      @(negedge clk);
      if (dm_a.dm_req) begin
        if (obs_req == 0) begin
          obs_addr = dm_a.dm_addr; obs_wdata = dm_a.dm_wdata;
          obs_strb = dm_a.dm_wstrb; obs_we = dm_a.dm_we;
        end else if (obs_addr !== dm_a.dm_addr || obs_wdata !== dm_a.dm_wdata ||
                     obs_strb !== dm_a.dm_wstrb || obs_we !== dm_a.dm_we) begin
          obs_stable = 1'b0;
        end
        obs_req++;
      end
      if (mem_stall) obs_stall++;
      if (mem_done) begin
        obs_done++; obs_lat = cyc; obs_rdata = mem_rdata_out; obs_err = mem_err;
      end
      @(posedge clk); #1;
      dm_a.dm_ack = 1'b0; dm_a.dm_rdata = '0;
      if (obs_done > 0 && cyc >= obs_lat + 2) break;
    end
  endtask

  task automatic no_access(input string tag, input logic valid, input logic [4:0] op);
    mem_valid_in = valid; mem_op = op; mem_addr = 32'h0000_0010;
    @(negedge clk);
    check({tag, "_stall"}, {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    mem_valid_in = 1'b0; mem_op = '0;
    @(negedge clk);
    check({tag, "_req"}, {30'b0, dm_a.dm_req, mem_done}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int req_n, done_at, done_n;
    logic err_seen;
    logic [31:0] rd_seen;

    dm_a.dm_ack = 1'b0; dm_a.dm_rdata = '0;
    dm_b.dm_ack = 1'b0; dm_b.dm_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, dm_a.dm_req}, 32'd0);
    check("rst_bus", dm_a.dm_addr | dm_a.dm_wdata | {28'b0, dm_a.dm_wstrb} | {31'b0, dm_a.dm_we}, 32'd0);
    check("rst_out", mem_rdata_out | {30'b0, mem_done, mem_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ld.w, ack in the first REQ cycle
    run_access(5'b10010, 32'h1000_0004, 32'h0, 0, 32'hDEAD_BEEF);
    check("ldw_addr",  obs_addr, 32'h1000_0004);
    check("ldw_strb",  {27'b0, obs_we, obs_strb}, 32'd0);
    check("ldw_lat",   32'(obs_lat), 32'd2);
    check("ldw_data",  obs_rdata, 32'hDEAD_BEEF);
    check("ldw_stall", 32'(obs_stall), 32'd2);
    check("ldw_done",  {31'b0, obs_err}, 32'd0);

    run_access(5'b10000, 32'h1000_0003, 32'h0, 0, 32'h8000_0000);
    check("ldb_data", obs_rdata, 32'hFFFF_FF80);
    run_access(5'b10100, 32'h1000_0003, 32'h0, 0, 32'h8000_0000);
    check("ldbu_data", obs_rdata, 32'h0000_0080);
    run_access(5'b10001, 32'h1000_0002, 32'h0, 0, 32'h1234_5678);
    check("ldh_data", obs_rdata, 32'h0000_1234);
    check("ldh_addr", obs_addr, 32'h1000_0000);
    run_access(5'b10001, 32'h1000_0000, 32'h0, 0, 32'h0000_8001);
    check("ldh_sext", obs_rdata, 32'hFFFF_8001);

    run_access(5'b01000, 32'h2000_0001, 32'h0000_00AB, 0, 32'h5555_5555);
    check("stb_we",    {31'b0, obs_we}, 32'd1);
    check("stb_strb",  {28'b0, obs_strb}, 32'h2);
    check("stb_wdata", obs_wdata, 32'hABAB_ABAB);
    check("stb_rdata", obs_rdata, 32'h0);
    run_access(5'b01001, 32'h2000_0002, 32'h0000_CDEF, 0, 32'h0);
    check("sth_strb",  {28'b0, obs_strb}, 32'hC);
    check("sth_wdata", obs_wdata, 32'hCDEF_CDEF);
    run_access(5'b01010, 32'h2000_0008, 32'h1357_9BDF, 0, 32'h0);
    check("stw_strb",  {28'b0, obs_strb}, 32'hF);
    check("stw_wdata", obs_wdata, 32'h1357_9BDF);

    // ack held off for five REQ cycles
    run_access(5'b10010, 32'h3000_0010, 32'h0, 5, 32'hA5A5_0F0F);
    check("dly_req",    32'(obs_req), 32'd6);
    check("dly_stable", {31'b0, obs_stable}, 32'd1);
    check("dly_stall",  32'(obs_stall), 32'd7);
    check("dly_done",   32'(obs_done), 32'd1);
    check("dly_lat",    32'(obs_lat), 32'd7);
    check("dly_data",   obs_rdata, 32'hA5A5_0F0F);

    no_access("ldst", 1'b1, 5'b11010);
    no_access("sz11", 1'b1, 5'b10011);
    no_access("novld", 1'b0, 5'b10010);

`ifdef MEM_ALIGN_CHECK_EN
    mem_valid_in = 1'b1; mem_op = 5'b10010; mem_addr = 32'h4000_0002;
    @(negedge clk);
    check("ale_stall", {31'b0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    mem_valid_in = 1'b0; mem_op = '0;
    @(negedge clk);
    check("ale_req", {31'b0, dm_a.dm_req}, 32'd0);
    check("ale_flags", {29'b0, mem_done, mem_err, mem_ale}, 32'h7);
    check("ale_data", mem_rdata_out, 32'h0);
    check("ale_stall2", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
`else
    run_access(5'b10010, 32'h4000_0002, 32'h0, 0, 32'h1122_3344);
    check("mis_addr", obs_addr, 32'h4000_0000);
    check("mis_req",  32'(obs_req), 32'd1);
    check("mis_data", obs_rdata, 32'h1122_3344);
    check("mis_err",  {31'b0, obs_err}, 32'd0);
`endif

    // reset pulsed while a request is outstanding
    mem_valid_in = 1'b1; mem_op = 5'b10010; mem_addr = 32'h5000_0000;
    @(posedge clk); #1;
    mem_valid_in = 1'b0; mem_op = '0;
    @(posedge clk); #2;
    check("rmid_req_pre", {31'b0, dm_a.dm_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("rmid_req", {31'b0, dm_a.dm_req}, 32'd0);
    check("rmid_stall", {31'b0, mem_stall}, 32'd0);
    #1;
    rst = 1'b0;
    dm_a.dm_ack = 1'b1; dm_a.dm_rdata = 32'hFFFF_FFFF;
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_done) done_n++;
      @(posedge clk); #1;
      dm_a.dm_ack = 1'b0;
    end
    check("rmid_done", 32'(done_n), 32'd0);
    check("rmid_data", mem_rdata_out, 32'h0);

    // TIMEOUT=3 instance: good load first so the abort visibly clears the result
    valid_b = 1'b1; op_b = 5'b10010; addr_b = 32'h6000_0000;
    @(posedge clk); #1;
    valid_b = 1'b0; op_b = '0;
    dm_b.dm_ack = 1'b1; dm_b.dm_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dm_b.dm_ack = 1'b0; dm_b.dm_rdata = '0;
    @(negedge clk);
    check("to_pre_data", rdata_b, 32'hCAFE_F00D);
    @(posedge clk); #1;

    valid_b = 1'b1; op_b = 5'b10010; addr_b = 32'h6000_0004;
    @(negedge clk);
    check("to_stall_acc", {31'b0, stall_b}, 32'd1);
    @(posedge clk); #1;
    valid_b = 1'b0; op_b = '0;
    req_n = 0; done_at = 0; err_seen = 1'b0; rd_seen = 32'hFFFF_FFFF;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (dm_b.dm_req) req_n++;
      if (done_b) begin done_at = cyc; err_seen = err_b; rd_seen = rdata_b; end
      @(posedge clk); #1;
    end
    check("to_req_cycles", 32'(req_n), 32'd3);
    check("to_done_at", 32'(done_at), 32'd4);
    check("to_err", {31'b0, err_seen}, 32'd1);
    check("to_data", rd_seen, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
